// File: rtl/mx_out_pkg.sv
// Shared types and helpers for the MX output drainer: wrapper mode encodings,
// the 8x8 element block type and element-width / beat-count helpers.
package mx_out_pkg;

    typedef enum logic [1:0] {
        PREC_INT8    = 2'b00,
        PREC_FP8_FP6 = 2'b01,
        PREC_RSVD    = 2'b10,
        PREC_FP4     = 2'b11
    } prec_e;

    typedef enum logic [1:0] {
        FP_E2M3 = 2'b00,
        FP_E3M2 = 2'b01,
        FP_E4M3 = 2'b10,
        FP_E5M2 = 2'b11
    } fp_e;

    typedef logic [0:7][0:7][7:0] pe_block_t;

    localparam int NUM_ELEMS = 64;
    localparam int PAYLOAD_W = 512;

    // Bits kept per element; the reserved precision code falls back to 8 bits.
    function automatic logic [3:0] elem_width(input prec_e prec, input fp_e fp);
        logic [3:0] w;
        w = 4'd8;
        case (prec)
            PREC_FP8_FP6: w = (fp == FP_E4M3 || fp == FP_E5M2) ? 4'd8 : 4'd6;
            PREC_FP4:     w = 4'd4;
            default:      w = 4'd8;
        endcase
        return w;
    endfunction

    function automatic int num_beats(input int w, input int data_w);
        return (NUM_ELEMS * w) / data_w;
    endfunction

endpackage

// File: rtl/mx_elem_packer.sv
// Packs the MSB-aligned 8x8 element block into a dense payload of 8/6/4-bit
// fields, element r*8+c at field index r*8+c; unused upper payload bits are zero.
module mx_elem_packer
    import mx_out_pkg::*;
(
    input  pe_block_t              i_block,
    input  logic [3:0]             i_width,
    output logic [PAYLOAD_W-1:0]   o_payload
);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        o_payload = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (i_width)
                    4'd4:    o_payload[(r*8+c)*4 +: 4] = i_block[r][c][7 -: 4];
                    4'd6:    o_payload[(r*8+c)*6 +: 6] = i_block[r][c][7 -: 6];
                    default: o_payload[(r*8+c)*8 +: 8] = i_block[r][c];
                endcase
            end
        end
    end

endmodule

// File: rtl/mx_output_drainer.sv
// Drains one requantized MX block from the Block_PE wrapper: raises send_output,
// captures Out/shared_exp after REQUANT_LAT cycles, then streams packed beats.
module mx_output_drainer
    import mx_out_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int REQUANT_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rstn,
    input  logic              drain_start,
    input  logic [1:0]        prec_mode_quan,
    input  logic [1:0]        FP_mode_quan,
    output logic              send_output,
    input  pe_block_t         pe_out,
    input  logic [7:0]        pe_shared_exp,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [7:0]        m_shared_exp,
    output logic              busy,
    output logic              done
);

    localparam int MAX_BEATS = PAYLOAD_W / DATA_W;
    localparam int CNT_W     = $clog2(MAX_BEATS);
    localparam int WAIT_W    = (REQUANT_LAT > 1) ? $clog2(REQUANT_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STREAM,
        ST_DONE
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_beat;
    logic [3:0]          r_width;
    pe_block_t           r_buf;
    logic [7:0]          r_shared_exp;

    logic                          w_req_end;
    logic [CNT_W-1:0]              w_last_idx;
    logic [PAYLOAD_W-1:0]          w_payload;
    logic [MAX_BEATS-1:0][DATA_W-1:0] w_beats;

    assign w_req_end  = (r_state == ST_REQ) && (r_wait == WAIT_W'(REQUANT_LAT - 1));
    assign w_last_idx = CNT_W'(num_beats(int'(r_width), DATA_W) - 1);

    mx_elem_packer u_packer (
        .i_block   (r_buf),
        .i_width   (r_width),
        .o_payload (w_payload)
    );

    assign w_beats      = w_payload;
    assign m_data       = w_beats[r_beat];
    assign m_shared_exp = r_shared_exp;

    // Outputs decode the registered state only, so m_valid never follows m_ready.
    always_comb begin
        w_state_nxt = r_state;
        send_output = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (drain_start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                send_output = 1'b1;
                if (w_req_end) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                m_valid = 1'b1;
                m_last  = (r_beat == w_last_idx);
                if (m_ready && (r_beat == w_last_idx)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: the capture buffer is reset too, so m_data reads zero out of reset.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_wait       <= '0;
            r_beat       <= '0;
            r_width      <= 4'd8;
            r_buf        <= '0;
            r_shared_exp <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (drain_start) begin
                        r_width <= elem_width(prec_e'(prec_mode_quan), fp_e'(FP_mode_quan));
                        r_wait  <= '0;
                        r_beat  <= '0;
                    end
                end
                ST_REQ: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_req_end) begin
                        r_buf        <= pe_out;
                        r_shared_exp <= pe_shared_exp;
                    end
                end
                ST_STREAM: begin
                    if (m_ready) r_beat <= r_beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
